// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate response checker: FSM states, bit positions
// of the stimulus and response vectors, and the golden gate model.
package gate_chk_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      HALT  = 2'd3
   } state_t;

   localparam int STIM_W = 4;
   localparam int RSP_W  = 5;

   // Response vector {x,y,w,u,v}
   localparam int X_BIT = 4;
   localparam int Y_BIT = 3;
   localparam int W_BIT = 2;
   localparam int U_BIT = 1;
   localparam int V_BIT = 0;

   // Stimulus vector {a,b,c,d}
   localparam int A_BIT = 3;
   localparam int B_BIT = 2;
   localparam int C_BIT = 1;
   localparam int D_BIT = 0;

   function automatic logic [RSP_W-1:0] gate_golden(input logic [STIM_W-1:0] abcd);
      logic [RSP_W-1:0] rsp;
      rsp        = '0;
      rsp[X_BIT] = abcd[A_BIT] | abcd[B_BIT];
      rsp[Y_BIT] = abcd[A_BIT] & abcd[B_BIT];
      rsp[W_BIT] = ~(abcd[A_BIT] | abcd[B_BIT]);
      rsp[U_BIT] = abcd[A_BIT] ^ abcd[B_BIT];
      rsp[V_BIT] = ~(abcd[C_BIT] & abcd[D_BIT]);
      return rsp;
   endfunction

endpackage

// File: rtl/gate_chk_cmp.sv
// Capture stage and golden-model compare for the gate checker.
// Optional macro GATE_CHK_FIRST_FAIL_EN exposes the captured stimulus so the
// top can latch the first failing vector.
module gate_chk_cmp
   import gate_chk_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              accept,
   input  logic              in_valid,
   input  logic [3:0]        in_abcd,
   input  logic [4:0]        dut_xywuv,
`ifdef GATE_CHK_FIRST_FAIL_EN
   output logic [3:0]        chk_abcd,
`endif
   output logic              chk_valid,
   output logic              chk_mismatch,
   output logic [4:0]        chk_mask
);

   logic [STIM_W-1:0] abcd_p1;
   logic [RSP_W-1:0]  xywuv_p1;
   logic              vld_p1;

   // Stage 1: valid bit tracks whether a sample was accepted on the last edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= accept & in_valid;
      end
   end

   // Stage 1: stimulus/response capture, only loaded on accepted samples
   always_ff @(posedge clk) begin
      if (accept && in_valid) begin
         abcd_p1  <= in_abcd;
         xywuv_p1 <= dut_xywuv;
      end
   end

   // Stage 2: combinational compare against the golden model
   assign chk_mask     = gate_golden(abcd_p1) ^ xywuv_p1;
   assign chk_mismatch = |chk_mask;
   assign chk_valid    = vld_p1;
`ifdef GATE_CHK_FIRST_FAIL_EN
   assign chk_abcd     = abcd_p1;
`endif

endmodule

// File: rtl/gate_checker.sv
// Sequential response checker for the x/y/w/u/v gate block. Samples are
// captured in RUN, compared one cycle later, and counted with saturating
// counters. Optional macro GATE_CHK_FIRST_FAIL_EN adds first-failure capture
// outputs (first_fail_abcd, first_fail_idx).
module gate_checker
   import gate_chk_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int HALT_ON_ERR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic              in_valid,
   input  logic [3:0]        in_abcd,
   input  logic [4:0]        dut_xywuv,
   output logic              busy,
   output logic              done,
   output logic              err_flag,
   output logic [CNT_W-1:0]  err_cnt,
   output logic [CNT_W-1:0]  sample_cnt,
   output logic [4:0]        mismatch_mask
`ifdef GATE_CHK_FIRST_FAIL_EN
   ,
   output logic [3:0]        first_fail_abcd,
   output logic [CNT_W-1:0]  first_fail_idx
`endif
);

   state_t      state, state_nxt;
   logic        accept;
   logic        chk_valid;
   logic        chk_mismatch;
   logic [4:0]  chk_mask;
   logic        chk_en;
   logic        run_clr;
`ifdef GATE_CHK_FIRST_FAIL_EN
   logic [3:0]  chk_abcd;
`endif

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
      return (&val) ? val : val + 1'b1;
   endfunction

   assign accept  = (state == RUN);
   // Results only count while a run is live; in HALT a captured sample is discarded
   assign chk_en  = chk_valid && ((state == RUN) || (state == DRAIN));
   assign run_clr = start && ((state == IDLE) || (state == HALT));
   assign busy    = (state == RUN) || (state == DRAIN);

   gate_chk_cmp u_cmp (
      .clk          (clk),
      .rst_n        (rst_n),
      .accept       (accept),
      .in_valid     (in_valid),
      .in_abcd      (in_abcd),
      .dut_xywuv    (dut_xywuv),
`ifdef GATE_CHK_FIRST_FAIL_EN
      .chk_abcd     (chk_abcd),
`endif
      .chk_valid    (chk_valid),
      .chk_mismatch (chk_mismatch),
      .chk_mask     (chk_mask)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state; an error-halt takes priority over a coincident stop
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN: begin
            if ((HALT_ON_ERR != 0) && chk_valid && chk_mismatch) state_nxt = HALT;
            else if (stop)                                      state_nxt = DRAIN;
         end
         DRAIN:   state_nxt = IDLE;
         HALT:    if (start) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   // Completion flag: set on leaving DRAIN or entering HALT, cleared by start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done <= 1'b0;
      end else if (run_clr) begin
         done <= 1'b0;
      end else if ((state == DRAIN) || (state_nxt == HALT)) begin
         done <= 1'b1;
      end
   end

   // Stage 2 result: saturating counters, sticky error flag and last mask
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_cnt    <= '0;
         err_cnt       <= '0;
         err_flag      <= 1'b0;
         mismatch_mask <= '0;
      end else if (run_clr) begin
         sample_cnt    <= '0;
         err_cnt       <= '0;
         err_flag      <= 1'b0;
         mismatch_mask <= '0;
      end else if (chk_en) begin
         sample_cnt    <= sat_inc(sample_cnt);
         mismatch_mask <= chk_mask;
         if (chk_mismatch) begin
            err_cnt  <= sat_inc(err_cnt);
            err_flag <= 1'b1;
         end
      end
   end

`ifdef GATE_CHK_FIRST_FAIL_EN
   // First failure of a run: err_flag still low means no earlier mismatch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_fail_abcd <= '0;
         first_fail_idx  <= '0;
      end else if (run_clr) begin
         first_fail_abcd <= '0;
         first_fail_idx  <= '0;
      end else if (chk_en && chk_mismatch && !err_flag) begin
         first_fail_abcd <= chk_abcd;
         first_fail_idx  <= sample_cnt;
      end
   end
`endif

endmodule

// File: tb/tb_gate_checker.sv
// Testbench for gate_checker: three instances (default, halt-on-error,
// 4-bit counters) share stimulus and are compared against a transaction-level
// model of a check run.
module tb_gate_checker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        stop;
   logic        in_valid;
   logic [3:0]  in_abcd;
   logic [4:0]  dut_xywuv;

   logic        busy_a, done_a, flag_a;
   logic [15:0] err_a, samp_a;
   logic [4:0]  mask_a;
   logic        busy_h, done_h, flag_h;
   logic [15:0] err_h, samp_h;
   logic [4:0]  mask_h;
   logic        busy_s, done_s, flag_s;
   logic [3:0]  err_s, samp_s;
   logic [4:0]  mask_s;

   logic        o_busy[3];
   logic        o_done[3];
   logic        o_flag[3];
   logic [15:0] o_err[3];
   logic [15:0] o_samp[3];
   logic [4:0]  o_mask[3];

`ifdef GATE_CHK_FIRST_FAIL_EN
   logic [3:0]  ffa_a, ffa_h, ffa_s;
   logic [15:0] ffi_a, ffi_h;
   logic [3:0]  ffi_s;
   logic [3:0]  o_ffa[3];
   logic [15:0] o_ffi[3];
   assign o_ffa[0] = ffa_a;
   assign o_ffa[1] = ffa_h;
   assign o_ffa[2] = ffa_s;
   assign o_ffi[0] = ffi_a;
   assign o_ffi[1] = ffi_h;
   assign o_ffi[2] = {12'd0, ffi_s};
`endif

   assign o_busy[0] = busy_a;  assign o_busy[1] = busy_h;  assign o_busy[2] = busy_s;
   assign o_done[0] = done_a;  assign o_done[1] = done_h;  assign o_done[2] = done_s;
   assign o_flag[0] = flag_a;  assign o_flag[1] = flag_h;  assign o_flag[2] = flag_s;
   assign o_err[0]  = err_a;   assign o_err[1]  = err_h;   assign o_err[2]  = {12'd0, err_s};
   assign o_samp[0] = samp_a;  assign o_samp[1] = samp_h;  assign o_samp[2] = {12'd0, samp_s};
   assign o_mask[0] = mask_a;  assign o_mask[1] = mask_h;  assign o_mask[2] = mask_s;

   gate_checker #(.CNT_W(16), .HALT_ON_ERR(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
      .in_abcd(in_abcd), .dut_xywuv(dut_xywuv), .busy(busy_a), .done(done_a),
      .err_flag(flag_a), .err_cnt(err_a), .sample_cnt(samp_a), .mismatch_mask(mask_a)
`ifdef GATE_CHK_FIRST_FAIL_EN
      , .first_fail_abcd(ffa_a), .first_fail_idx(ffi_a)
`endif
   );

   gate_checker #(.CNT_W(16), .HALT_ON_ERR(1)) u_halt (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
      .in_abcd(in_abcd), .dut_xywuv(dut_xywuv), .busy(busy_h), .done(done_h),
      .err_flag(flag_h), .err_cnt(err_h), .sample_cnt(samp_h), .mismatch_mask(mask_h)
`ifdef GATE_CHK_FIRST_FAIL_EN
      , .first_fail_abcd(ffa_h), .first_fail_idx(ffi_h)
`endif
   );

   gate_checker #(.CNT_W(4), .HALT_ON_ERR(0)) u_sat (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
      .in_abcd(in_abcd), .dut_xywuv(dut_xywuv), .busy(busy_s), .done(done_s),
      .err_flag(flag_s), .err_cnt(err_s), .sample_cnt(samp_s), .mismatch_mask(mask_s)
`ifdef GATE_CHK_FIRST_FAIL_EN
      , .first_fail_abcd(ffa_s), .first_fail_idx(ffi_s)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Run-level reference model, one entry per instance
   logic [15:0] m_max[3];
   bit          m_halt[3];
   bit          m_run[3];
   bit          m_done[3];
   bit          m_flag[3];
   logic [15:0] m_samp[3];
   logic [15:0] m_err[3];
   logic [4:0]  m_mask[3];
   logic [15:0] m_ff_idx[3];
   logic [3:0]  m_ff_abcd[3];

   // Gate truth from counts of high inputs
   function automatic logic [4:0] ref_gate(input logic [3:0] s);
      int ab, cd;
      logic [4:0] r;
      ab = int'(s[3]) + int'(s[2]);
      cd = int'(s[1]) + int'(s[0]);
      r[4] = (ab != 0);
      r[3] = (ab == 2);
      r[2] = (ab == 0);
      r[1] = (ab == 1);
      r[0] = (cd != 2);
      return r;
   endfunction

   function automatic void m_reset();
      for (int i = 0; i < 3; i++) begin
         m_run[i] = 0; m_done[i] = 0; m_flag[i] = 0;
         m_samp[i] = '0; m_err[i] = '0; m_mask[i] = '0;
         m_ff_idx[i] = '0; m_ff_abcd[i] = '0;
      end
   endfunction

   function automatic void m_start();
      for (int i = 0; i < 3; i++) begin
         if (!m_run[i]) begin
            m_run[i] = 1; m_done[i] = 0; m_flag[i] = 0;
            m_samp[i] = '0; m_err[i] = '0; m_mask[i] = '0;
            m_ff_idx[i] = '0; m_ff_abcd[i] = '0;
         end
      end
   endfunction

   function automatic void m_stop();
      for (int i = 0; i < 3; i++) begin
         if (m_run[i]) begin
            m_run[i] = 0; m_done[i] = 1;
         end
      end
   endfunction

   function automatic void m_sample(input logic [3:0] s, input logic [4:0] resp);
      logic [4:0] d;
      d = ref_gate(s) ^ resp;
      for (int i = 0; i < 3; i++) begin
         if (m_run[i]) begin
            if (d != 5'd0 && !m_flag[i]) begin
               m_ff_idx[i]  = m_samp[i];
               m_ff_abcd[i] = s;
            end
            if (m_samp[i] < m_max[i]) m_samp[i] = m_samp[i] + 16'd1;
            m_mask[i] = d;
            if (d != 5'd0) begin
               if (m_err[i] < m_max[i]) m_err[i] = m_err[i] + 16'd1;
               m_flag[i] = 1;
               if (m_halt[i]) begin
                  m_run[i] = 0; m_done[i] = 1;
               end
            end
         end
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      m_start();
   endtask

   task automatic send(input logic [3:0] s, input logic [4:0] resp);
      in_valid  = 1'b1;
      in_abcd   = s;
      dut_xywuv = resp;
      tick();
      in_valid  = 1'b0;
      m_sample(s, resp);
   endtask

   task automatic finish_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      m_stop();
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
      in_abcd = '0; dut_xywuv = '0;
      m_reset();
      tick();
      tick();
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if ({o_busy[i], o_done[i], o_flag[i]} !== 3'b000 || o_err[i] !== 16'd0 ||
             o_samp[i] !== 16'd0 || o_mask[i] !== 5'd0) begin
            n_errors++;
            $display("FAIL reset[%0d]: busy=%b done=%b flag=%b err=%0d samp=%0d mask=%b, need all zero",
                     i, o_busy[i], o_done[i], o_flag[i], o_err[i], o_samp[i], o_mask[i]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_stream();
      pulse_start();
      for (int v = 0; v < 15; v++) send(4'(v), ref_gate(4'(v)));
      // last sample rides along with stop
      in_valid = 1'b1; in_abcd = 4'hF; dut_xywuv = ref_gate(4'hF); stop = 1'b1;
      tick();
      in_valid = 1'b0; stop = 1'b0;
      m_sample(4'hF, ref_gate(4'hF));
      m_stop();
      n_checks++;
      if (done_a !== 1'b0 || busy_a !== 1'b1) begin
         n_errors++;
         $display("FAIL stream_drain: done=%b busy=%b, need done=0 busy=1", done_a, busy_a);
      end
      tick();
      n_checks++;
      if (done_a !== 1'b1 || busy_a !== 1'b0 || samp_a !== 16'd16 || err_a !== 16'd0 || flag_a !== 1'b0) begin
         n_errors++;
         $display("FAIL stream_end: done=%b busy=%b samp=%0d err=%0d flag=%b, need 1 0 16 0 0",
                  done_a, busy_a, samp_a, err_a, flag_a);
      end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (o_samp[i] !== m_samp[i] || o_err[i] !== m_err[i] || o_done[i] !== m_done[i]) begin
            n_errors++;
            $display("FAIL stream_model[%0d]: samp=%0d err=%0d done=%b, need %0d %0d %b",
                     i, o_samp[i], o_err[i], o_done[i], m_samp[i], m_err[i], m_done[i]);
         end
      end
   endtask

   task automatic test_mask();
      logic [3:0] good [3];
      good = '{4'd3, 4'd9, 4'd12};
      pulse_start();
      send(4'b1100, 5'b11000);
      tick();
      n_checks++;
      if (mask_a !== 5'b00001 || err_a !== 16'd1 || flag_a !== 1'b1 || samp_a !== 16'd1) begin
         n_errors++;
         $display("FAIL mask_err: mask=%b err=%0d flag=%b samp=%0d, need 00001 1 1 1",
                  mask_a, err_a, flag_a, samp_a);
      end
      for (int k = 0; k < 3; k++) send(good[k], ref_gate(good[k]));
      tick();
      n_checks++;
      if (samp_a !== 16'd4 || err_a !== 16'd1 || flag_a !== 1'b1 || mask_a !== 5'b00000) begin
         n_errors++;
         $display("FAIL mask_cont: samp=%0d err=%0d flag=%b mask=%b, need 4 1 1 00000",
                  samp_a, err_a, flag_a, mask_a);
      end
      finish_stop();
   endtask

   task automatic test_halt();
      logic [31:0] r;
      logic [3:0]  s;
      pulse_start();
      for (int k = 0; k < 8; k++) begin
         r = $urandom;
         s = r[3:0];
         send(s, ref_gate(s) ^ ((k == 4) ? 5'b00100 : 5'b00000));
      end
      tick();
      tick();
      n_checks++;
      if (samp_h !== 16'd5 || err_h !== 16'd1 || done_h !== 1'b1 || busy_h !== 1'b0 || flag_h !== 1'b1) begin
         n_errors++;
         $display("FAIL halt_state: samp=%0d err=%0d done=%b busy=%b flag=%b, need 5 1 1 0 1",
                  samp_h, err_h, done_h, busy_h, flag_h);
      end
      // in_valid while halted is ignored
      for (int k = 0; k < 3; k++) send(4'(k), 5'b11111);
      tick();
      n_checks++;
      if (samp_h !== 16'd5 || err_h !== 16'd1) begin
         n_errors++;
         $display("FAIL halt_frozen: samp=%0d err=%0d, need 5 1", samp_h, err_h);
      end
      pulse_start();
      n_checks++;
      if (samp_h !== 16'd0 || err_h !== 16'd0 || flag_h !== 1'b0 || done_h !== 1'b0 || busy_h !== 1'b1) begin
         n_errors++;
         $display("FAIL halt_restart: samp=%0d err=%0d flag=%b done=%b busy=%b, need 0 0 0 0 1",
                  samp_h, err_h, flag_h, done_h, busy_h);
      end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (o_samp[i] !== m_samp[i] || o_err[i] !== m_err[i] || o_busy[i] !== m_run[i]) begin
            n_errors++;
            $display("FAIL halt_model[%0d]: samp=%0d err=%0d busy=%b, need %0d %0d %b",
                     i, o_samp[i], o_err[i], o_busy[i], m_samp[i], m_err[i], m_run[i]);
         end
      end
      finish_stop();
   endtask

   task automatic test_saturate();
      pulse_start();
      for (int k = 0; k < 20; k++) send(4'(k), ref_gate(4'(k)) ^ 5'b10000);
      tick();
      n_checks++;
      if (samp_s !== 4'd15 || err_s !== 4'd15 || flag_s !== 1'b1) begin
         n_errors++;
         $display("FAIL sat_cnt: samp=%0d err=%0d flag=%b, need 15 15 1", samp_s, err_s, flag_s);
      end
      n_checks++;
      if (samp_a !== 16'd20 || err_a !== 16'd20) begin
         n_errors++;
         $display("FAIL sat_wide: samp=%0d err=%0d, need 20 20", samp_a, err_a);
      end
      finish_stop();
   endtask

   task automatic test_random();
      logic [31:0] r;
      logic [3:0]  s;
      pulse_start();
      for (int k = 0; k < 80; k++) begin
         r = $urandom;
         s = r[3:0];
         if (r[5:4] != 2'b00) send(s, ref_gate(s) ^ ((r[8:6] == 3'd0) ? r[13:9] : 5'd0));
         else tick();
      end
      finish_stop();
      // traffic while idle must be dropped
      for (int k = 0; k < 5; k++) begin
         r = $urandom;
         send(r[3:0], r[8:4]);
      end
      tick();
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (o_samp[i] !== m_samp[i] || o_err[i] !== m_err[i] || o_flag[i] !== m_flag[i] ||
             o_mask[i] !== m_mask[i] || o_done[i] !== m_done[i] || o_busy[i] !== m_run[i]) begin
            n_errors++;
            $display("FAIL random[%0d]: samp=%0d err=%0d flag=%b mask=%b done=%b busy=%b, need %0d %0d %b %b %b %b",
                     i, o_samp[i], o_err[i], o_flag[i], o_mask[i], o_done[i], o_busy[i],
                     m_samp[i], m_err[i], m_flag[i], m_mask[i], m_done[i], m_run[i]);
         end
      end
   endtask

   task automatic test_reset_midrun();
      pulse_start();
      for (int k = 0; k < 7; k++) send(4'(k + 3), ref_gate(4'(k + 3)) ^ ((k == 2) ? 5'b01000 : 5'd0));
      in_valid = 1'b1; in_abcd = 4'd5; dut_xywuv = 5'b00000;
      @(posedge clk);
      #3;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      m_reset();
      #1;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if ({o_busy[i], o_done[i], o_flag[i]} !== 3'b000 || o_err[i] !== 16'd0 ||
             o_samp[i] !== 16'd0 || o_mask[i] !== 5'd0) begin
            n_errors++;
            $display("FAIL async_rst[%0d]: busy=%b done=%b flag=%b err=%0d samp=%0d mask=%b, need all zero",
                     i, o_busy[i], o_done[i], o_flag[i], o_err[i], o_samp[i], o_mask[i]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      for (int k = 0; k < 5; k++) send(4'(k), 5'b11111);
      tick();
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (o_samp[i] !== 16'd0 || o_err[i] !== 16'd0 || o_busy[i] !== 1'b0 || o_done[i] !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_drop[%0d]: samp=%0d err=%0d busy=%b done=%b, need 0 0 0 0",
                     i, o_samp[i], o_err[i], o_busy[i], o_done[i]);
         end
      end
   endtask

`ifdef GATE_CHK_FIRST_FAIL_EN
   task automatic test_first_fail();
      logic [3:0] s;
      pulse_start();
      for (int k = 0; k < 8; k++) begin
         s = (k == 3) ? 4'b0110 : 4'(k * 5);
         send(s, ref_gate(s) ^ ((k == 3 || k == 6) ? 5'b00010 : 5'd0));
      end
      tick();
      n_checks++;
      if (ffi_a !== 16'd3 || ffa_a !== 4'b0110) begin
         n_errors++;
         $display("FAIL first_fail: idx=%0d abcd=%b, need 3 0110", ffi_a, ffa_a);
      end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (o_ffi[i] !== m_ff_idx[i] || o_ffa[i] !== m_ff_abcd[i]) begin
            n_errors++;
            $display("FAIL first_fail_model[%0d]: idx=%0d abcd=%b, need %0d %b",
                     i, o_ffi[i], o_ffa[i], m_ff_idx[i], m_ff_abcd[i]);
         end
      end
      finish_stop();
      n_checks++;
      if (ffi_a !== 16'd3 || ffa_a !== 4'b0110) begin
         n_errors++;
         $display("FAIL first_fail_hold: idx=%0d abcd=%b, need 3 0110", ffi_a, ffa_a);
      end
      pulse_start();
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (o_ffi[i] !== 16'd0 || o_ffa[i] !== 4'd0) begin
            n_errors++;
            $display("FAIL first_fail_clr[%0d]: idx=%0d abcd=%b, need 0 0000", i, o_ffi[i], o_ffa[i]);
         end
      end
      finish_stop();
   endtask
`endif

   initial begin
      m_max  = '{16'd65535, 16'd65535, 16'd15};
      m_halt = '{1'b0, 1'b1, 1'b0};
      test_reset();
      test_stream();
      test_mask();
      test_halt();
      test_saturate();
      test_random();
      test_reset_midrun();
`ifdef GATE_CHK_FIRST_FAIL_EN
      test_first_fail();
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/gate_checker.md
Name: gate_checker

Overview:
- Sequential response checker for the two-input/four-input logic gate block (outputs x, y, w, u, v).
- Takes each stimulus vector driven into the gate, together with the gate's combinational outputs, and compares them against a golden model.
- Accumulates sample and error counts, flags mismatches, and optionally halts on first error.
- Sits in the example testbench/self-check wrapper as the consumer of the gate's outputs.

Parameters:
- CNT_W, 16, width of sample and error counters.
- HALT_ON_ERR, 0, 1 = enter HALT on the first mismatch; 0 = keep running.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  pulse; begins a check run from IDLE.
- stop  input  1  pulse; ends the run.
- in_valid  input  1  stimulus/response pair valid this cycle.
- in_abcd  input  4  stimulus {a,b,c,d}; bit 3 = a.
- dut_xywuv  input  5  gate response {x,y,w,u,v}; bit 4 = x.
- busy  output  1  high in RUN or DRAIN.
- done  output  1  high in IDLE after a completed run; cleared by start.
- err_flag  output  1  sticky; set on any mismatch in the current run.
- err_cnt  output  CNT_W  mismatching samples in the current run.
- sample_cnt  output  CNT_W  samples checked in the current run.
- mismatch_mask  output  5  per-output XOR of expected vs actual for the most recent checked sample.

Behaviour:
- Reset (async assert, sync deassert at the next edge): state=IDLE; busy=0, done=0, err_flag=0, err_cnt=0, sample_cnt=0, mismatch_mask=0; pipeline valid bit=0.
- Golden model: x=a|b, y=a&b, w=~(a|b), u=a^b, v=~(c&d).
- Stage 1: on an edge with in_valid=1 and state==RUN, register in_abcd, dut_xywuv, and set the stage-1 valid bit.
- Stage 2: if the stage-1 valid bit is set, compare combinationally against the golden model. On the next edge:
  - sample_cnt += 1.
  - mismatch_mask is updated.
  - if the mask is nonzero: err_cnt += 1 and err_flag is set.
- Latency: a sample accepted at edge N is reflected in the outputs after edge N+1.
- Counters saturate at 2^CNT_W-1 and never wrap. Saturated err_cnt still keeps err_flag=1.
- States:
  - IDLE: start=1 -> RUN. Same edge clears err_flag, err_cnt, sample_cnt, mismatch_mask and done.
  - RUN: stop=1 -> DRAIN; in_valid on the same cycle is still accepted. A mismatch at stage 2 with HALT_ON_ERR=1 -> HALT.
  - DRAIN: one cycle; stage 2 completes the in-flight sample; no new samples accepted -> IDLE with done=1.
  - HALT: busy=0, done=1, counters frozen, in_valid ignored. Samples still in stage 1 are discarded. start -> RUN with counters cleared.
- Simultaneous events:
  - start and stop together in IDLE/HALT: start wins.
  - start in RUN/DRAIN: ignored.
  - stop in IDLE/HALT: ignored.
  - A mismatch in DRAIN with HALT_ON_ERR=1: counted, next state is IDLE (not HALT).
- in_valid outside RUN: dropped, not counted.
- Reset mid-run: everything returns to reset values immediately; the in-flight sample is lost.

Optional Feature:
- Macro: GATE_CHK_FIRST_FAIL_EN.
- When defined: adds outputs first_fail_abcd[3:0] and first_fail_idx[CNT_W-1:0]. These latch the stimulus and the sample index (the sample_cnt value before increment) of the first mismatch in a run. Both reset to 0, clear on start, and hold until the next start or reset.
- When not defined: these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Package gate_chk_pkg holds:
  - state enum {IDLE, RUN, DRAIN, HALT}.
  - bit-index constants for {x,y,w,u,v} and {a,b,c,d}.
  - a function gate_golden(abcd) returning the 5-bit expected vector.
- One natural sub-module: gate_chk_cmp. It contains the stage-1 register plus the stage-2 compare and produces mismatch, mask and a valid pulse. The top module keeps the FSM and counters.

Test Plan:
- Start, stream all 16 abcd values with a correct DUT model, stop -> sample_cnt=16, err_cnt=0, err_flag=0, done=1 two cycles after stop.
- HALT_ON_ERR=0, abcd=4'b1100 with dut_xywuv=5'b11000 (v wrong; expected 5'b11001) -> mismatch_mask=5'b00001, err_cnt=1, err_flag=1. Continue 3 good samples -> sample_cnt=4, err_cnt stays 1.
- HALT_ON_ERR=1, error on the 5th sample followed by 3 more in_valid -> state HALT, sample_cnt=5, err_cnt=1, done=1, busy=0. start -> counters=0.
- CNT_W=4: feed 20 erroneous samples -> err_cnt=sample_cnt=15 (saturated), err_flag=1.
- Assert rst_n=0 mid-run after 7 samples -> all outputs 0 asynchronously. in_valid in IDLE for 5 cycles -> sample_cnt stays 0.
- With GATE_CHK_FIRST_FAIL_EN: errors at sample indices 3 (abcd=4'b0110) and 6 -> first_fail_idx=3, first_fail_abcd=4'b0110. Both clear on start.
